// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the I2C register-file target.
// Holds the protocol FSM state encoding and the ACK/NACK and R/W bit levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } i2c_state_t;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus FILT_LEN-sample glitch filter for one open-drain line.
// Filtered level and its rise/fall pulses appear 2+FILT_LEN clocks after a pin change.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0] r_sync;
    logic [2:0] r_cnt;
    logic       r_level;
    logic       r_rise;
    logic       r_fall;

    // r_cnt counts consecutive synchronised samples that disagree with the held level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == 3'(FILT_LEN - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
                r_fall  <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_regfile_target.sv
// I2C target exposing REGCOUNT byte registers plus a read-only mirror of parallel_in.
// Pointer auto-increments and wraps after the mirror slot; sda_oe changes only on SCL falls.
module i2c_regfile_target
    import i2c_pkg::*;
#(
    parameter int         REGCOUNT = 20,
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         FILT_LEN = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    input  logic [7:0]            parallel_in,
    output logic [8*REGCOUNT-1:0] registers_packed,
    output logic                  write_strobe,
    output logic [6:0]            write_index,
    output logic                  busy
);

    logic w_scl_f, w_scl_rise, w_scl_fall;
    logic w_sda_f, w_sda_rise, w_sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .i_clk(clock), .i_rst(reset), .i_pin(scl_in),
        .o_level(w_scl_f), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .i_clk(clock), .i_rst(reset), .i_pin(sda_in),
        .o_level(w_sda_f), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    i2c_state_t r_state, w_state_nxt;
    logic [7:0] r_shift;
    logic [2:0] r_cnt;
    logic [6:0] r_ptr;
    logic       r_sda_oe, r_busy, r_strobe;
    logic [6:0] r_windex;
    logic [7:0] r_regs [REGCOUNT];

    logic       w_start, w_stop;
    logic [7:0] w_byte, w_rd_byte;
    logic [6:0] w_ptr_next;
    logic       w_sda_set, w_sda_clr, w_shift_in, w_shift_out, w_load;
    logic       w_commit, w_cnt_inc, w_cnt_clr, w_ptr_load, w_ptr_inc;

    assign w_start    = w_sda_fall & w_scl_f;
    assign w_stop     = w_sda_rise & w_scl_f;
    assign w_byte     = {r_shift[6:0], w_sda_f};
    assign w_ptr_next = (r_ptr == 7'(REGCOUNT)) ? 7'd0 : r_ptr + 7'd1;

    always_comb begin
        w_rd_byte = parallel_in;
        for (int i = 0; i < REGCOUNT; i++) begin
            if (r_ptr == 7'(i)) w_rd_byte = r_regs[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sda_set   = 1'b0;
        w_sda_clr   = 1'b0;
        w_shift_in  = 1'b0;
        w_shift_out = 1'b0;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_ptr_load  = 1'b0;
        w_ptr_inc   = 1'b0;
        if (w_start) begin
            w_state_nxt = ADDR;
            w_cnt_clr   = 1'b1;
        end else if (w_stop) begin
            w_state_nxt = IDLE;
            w_sda_clr   = 1'b1;
        end else begin
            case (r_state)
                ADDR, PTR, WDATA: begin
                    w_sda_clr = w_scl_fall;
                    if (w_scl_rise) begin
                        w_shift_in = 1'b1;
                        w_cnt_inc  = 1'b1;
                        if (r_cnt == 3'd7) begin
                            w_cnt_clr = 1'b1;
                            if (r_state == ADDR) begin
                                w_state_nxt = (w_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IDLE;
                            end else if (r_state == PTR) begin
                                w_ptr_load  = (w_byte <= 8'(REGCOUNT));
                                w_state_nxt = w_ptr_load ? PTR_ACK : IDLE;
                            end else begin
                                w_commit    = (r_ptr < 7'(REGCOUNT));
                                w_ptr_inc   = 1'b1;
                                w_state_nxt = WDATA_ACK;
                            end
                        end
                    end
                end
                // ACK is driven across the 9th clock; the next state owns the 9th fall.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    w_sda_set = w_scl_fall;
                    if (w_scl_rise) begin
                        w_cnt_clr = 1'b1;
                        if (r_state == ADDR_ACK && r_shift[0] == I2C_RW_READ) begin
                            w_state_nxt = RDATA;
                            w_load      = 1'b1;
                            w_ptr_inc   = 1'b1;
                        end else begin
                            w_state_nxt = (r_state == ADDR_ACK) ? PTR : WDATA;
                        end
                    end
                end
                RDATA: begin
                    w_shift_out = w_scl_fall;
                    if (w_scl_rise) begin
                        w_cnt_inc = 1'b1;
                        if (r_cnt == 3'd7) begin
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = RDATA_ACK;
                        end
                    end
                end
                RDATA_ACK: begin
                    w_sda_clr = w_scl_fall;
                    if (w_scl_rise) begin
                        w_cnt_clr = 1'b1;
                        if (w_sda_f == I2C_ACK) begin
                            w_state_nxt = RDATA;
                            w_load      = 1'b1;
                            w_ptr_inc   = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_strobe <= 1'b0;
            r_windex <= '0;
            for (int i = 0; i < REGCOUNT; i++) r_regs[i] <= '0;
        end else begin
            r_strobe <= w_commit;
            if (w_start)     r_busy <= 1'b1;
            else if (w_stop) r_busy <= 1'b0;
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 3'd1;
            if (w_ptr_load)     r_ptr <= w_byte[6:0];
            else if (w_ptr_inc) r_ptr <= w_ptr_next;
            if (w_load)          r_shift <= w_rd_byte;
            else if (w_shift_in) r_shift <= w_byte;
            if (w_sda_clr) begin
                r_sda_oe <= 1'b0;
            end else if (w_sda_set) begin
                r_sda_oe <= 1'b1;
            end else if (w_shift_out) begin
                r_sda_oe <= ~r_shift[7];
                r_shift  <= {r_shift[6:0], 1'b0};
            end
            if (w_commit) begin
                r_windex <= r_ptr;
                for (int i = 0; i < REGCOUNT; i++) begin
                    if (r_ptr == 7'(i)) r_regs[i] <= w_byte;
                end
            end
        end
    end

    for (genvar g = 0; g < REGCOUNT; g++) begin : g_pack
        assign registers_packed[8*g +: 8] = r_regs[g];
    end

    assign sda_oe       = r_sda_oe;
    assign write_strobe = r_strobe;
    assign write_index  = r_windex;
    assign busy         = r_busy;

endmodule

// File: tb/tb_i2c_regfile_target.sv
// Directed bench: bit-banged I2C controller against the register-file target.
module tb_i2c_regfile_target;

    localparam int RC = 20;
    localparam int Q  = 10;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            r_scl = 1'b1;
    logic            r_sda_m = 1'b1;
    logic            glitch = 1'b0;
    logic [7:0]      parallel_in = 8'h00;
    logic            sda_in;
    logic            sda_oe;
    logic [8*RC-1:0] registers_packed;
    logic            write_strobe;
    logic [6:0]      write_index;
    logic            busy;

    assign sda_in = r_sda_m & ~sda_oe;

    i2c_regfile_target #(.REGCOUNT(RC), .DEV_ADDR(7'h42), .FILT_LEN(3)) dut (
        .clock(clock), .reset(reset), .scl_in(r_scl), .sda_in(sda_in),
        .sda_oe(sda_oe), .parallel_in(parallel_in), .registers_packed(registers_packed),
        .write_strobe(write_strobe), .write_index(write_index), .busy(busy)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_regs [RC];
    int         strobe_log [64];
    int         strobe_cnt = 0;
    logic       mon_en = 1'b0;
    logic       saw_oe = 1'b0;

    always @(negedge clock) begin
        if (write_strobe && strobe_cnt < 64) begin
            strobe_log[strobe_cnt] = int'(write_index);
            strobe_cnt = strobe_cnt + 1;
        end
        if (!mon_en)     saw_oe = 1'b0;
        else if (sda_oe) saw_oe = 1'b1;
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] exp_vec();
        logic [159:0] v = '0;
        for (int i = 0; i < RC; i++) v[8*i +: 8] = exp_regs[i];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One controller-driven bit; returns sda_oe seen mid-high-phase.
    task automatic bit_out(input logic b, output logic oe_seen);
        tick(Q); r_sda_m = b; tick(Q); r_scl = 1'b1;
        if (glitch) begin
            tick(Q/2); r_scl = 1'b0; tick(1); r_scl = 1'b1; tick(Q/2 - 1);
        end else begin
            tick(Q);
        end
        oe_seen = sda_oe;
        tick(Q); r_scl = 1'b0;
    endtask

    task automatic bit_in(output logic b);
        tick(Q); r_sda_m = 1'b1; tick(Q); r_scl = 1'b1;
        tick(Q); b = sda_in;
        tick(Q); r_scl = 1'b0;
    endtask

    task automatic i2c_start();
        tick(Q); r_sda_m = 1'b1; tick(Q); r_scl = 1'b1;
        tick(Q); r_sda_m = 1'b0; tick(Q); r_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(Q); r_sda_m = 1'b0; tick(Q); r_scl = 1'b1;
        tick(Q); r_sda_m = 1'b1; tick(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic x;
        for (int i = 7; i >= 0; i--) bit_out(d[i], x);
        bit_out(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic x;
        for (int i = 7; i >= 0; i--) bit_in(d[i]);
        bit_out(nack, x);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic       ok;
        logic [7:0] d;
        int         base;
        for (int i = 0; i < RC; i++) exp_regs[i] = 8'h00;

        tick(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", write_strobe, 0);
        chk("rst_windex", write_index, 0);
        chk("rst_regs", registers_packed, exp_vec());
        reset = 1'b0;
        tick(2*Q);

        // Plain write at pointer 5.
        base = strobe_cnt;
        i2c_start();
        send_byte(8'h84, ack); chk("t1_addr_ack", ack, 1);
        send_byte(8'h05, ack); chk("t1_ptr_ack", ack, 1);
        send_byte(8'hAA, ack); chk("t1_d0_ack", ack, 1);
        send_byte(8'h55, ack); chk("t1_d1_ack", ack, 1);
        chk("t1_busy_hi", busy, 1);
        i2c_stop();
        exp_regs[5] = 8'hAA; exp_regs[6] = 8'h55;
        chk("t1_regs", registers_packed, exp_vec());
        chk("t1_nstrobe", strobe_cnt - base, 2);
        chk("t1_idx0", strobe_log[base], 5);
        chk("t1_idx1", strobe_log[base + 1], 6);
        chk("t1_busy_lo", busy, 0);

        // Write across the mirror slot: second byte lands at index 20 and is dropped.
        base = strobe_cnt;
        i2c_start();
        send_byte(8'h84, ack); chk("t2_addr_ack", ack, 1);
        send_byte(8'h13, ack); chk("t2_ptr_ack", ack, 1);
        send_byte(8'h11, ack); chk("t2_d0_ack", ack, 1);
        send_byte(8'h22, ack); chk("t2_mirror_ack", ack, 1);
        i2c_stop();
        exp_regs[19] = 8'h11;
        chk("t2_regs", registers_packed, exp_vec());
        chk("t2_nstrobe", strobe_cnt - base, 1);
        chk("t2_idx", strobe_log[base], 19);

        // Combined write-pointer / repeated-START read of reg19 then the mirror.
        parallel_in = 8'h3C;
        base = strobe_cnt;
        i2c_start();
        send_byte(8'h84, ack); chk("t3_addr_ack", ack, 1);
        send_byte(8'h13, ack); chk("t3_ptr_ack", ack, 1);
        i2c_start();
        send_byte(8'h85, ack); chk("t3_raddr_ack", ack, 1);
        recv_byte(1'b0, d); chk("t3_rd0", d, 8'h11);
        recv_byte(1'b1, d); chk("t3_rd1", d, 8'h3C);
        tick(Q);
        chk("t3_released", sda_oe, 0);
        i2c_stop();
        chk("t3_nstrobe", strobe_cnt - base, 0);

        // Out-of-range pointer, then a foreign address.
        i2c_start();
        send_byte(8'h84, ack); chk("t4_addr_ack", ack, 1);
        send_byte(8'h15, ack); chk("t4_ptr_nack", ack, 0);
        i2c_stop();
        chk("t4_regs", registers_packed, exp_vec());
        mon_en = 1'b1;
        i2c_start();
        send_byte(8'h86, ack); chk("t4_addr_nack", ack, 0);
        send_byte(8'h00, ack); chk("t4_ignored", ack, 0);
        chk("t4_busy_kept", busy, 1);
        i2c_stop();
        tick(2);
        chk("t4_oe_quiet", saw_oe, 0);
        mon_en = 1'b0;

        // Short SCL low glitches during every high phase.
        base = strobe_cnt;
        glitch = 1'b1;
        i2c_start();
        send_byte(8'h84, ack); chk("t5_addr_ack", ack, 1);
        send_byte(8'h02, ack); chk("t5_ptr_ack", ack, 1);
        send_byte(8'hC3, ack); chk("t5_d_ack", ack, 1);
        glitch = 1'b0;
        i2c_stop();
        exp_regs[2] = 8'hC3;
        chk("t5_regs", registers_packed, exp_vec());
        chk("t5_nstrobe", strobe_cnt - base, 1);
        chk("t5_idx", strobe_log[base], 2);

        // Reset while the target is driving a 0 data bit of reg6 (0x55).
        i2c_start();
        send_byte(8'h84, ack); chk("t6_addr_ack", ack, 1);
        send_byte(8'h06, ack); chk("t6_ptr_ack", ack, 1);
        i2c_start();
        send_byte(8'h85, ack); chk("t6_raddr_ack", ack, 1);
        ok = 1'b0;
        for (int k = 0; k < 2*Q && !ok; k++) begin
            tick(1);
            if (sda_oe) ok = 1'b1;
        end
        chk("t6_oe_driven", ok, 1);
        reset = 1'b1;
        tick(1);
        chk("t6_oe_rel", sda_oe, 0);
        chk("t6_busy", busy, 0);
        for (int i = 0; i < RC; i++) exp_regs[i] = 8'h00;
        chk("t6_regs_clr", registers_packed, exp_vec());
        reset = 1'b0;
        r_sda_m = 1'b1; r_scl = 1'b1;
        tick(4*Q);
        base = strobe_cnt;
        i2c_start();
        send_byte(8'h84, ack); chk("t6b_addr_ack", ack, 1);
        send_byte(8'h03, ack); chk("t6b_ptr_ack", ack, 1);
        send_byte(8'h99, ack); chk("t6b_d_ack", ack, 1);
        i2c_stop();
        exp_regs[3] = 8'h99;
        chk("t6b_regs", registers_packed, exp_vec());
        chk("t6b_nstrobe", strobe_cnt - base, 1);
        chk("t6b_idx", strobe_log[base], 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
